// File: rtl/fpadd_arbiter_if.sv
// Requester/consumer bundle for fpadd_arbiter.
// The req_sub lane exists only when FPADD_ARB_SUB_EN is defined.
interface fpadd_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
`ifdef FPADD_ARB_SUB_EN
    logic [NREQ-1:0]    req_sub;
`endif
    logic [NREQ-1:0]    req_ready;
    logic               resp_valid;
    logic [31:0]        resp_sum;
    logic [ID_W-1:0]    resp_id;
    logic               resp_ready;

`ifdef FPADD_ARB_SUB_EN
    modport slave (
        input  req_valid, req_a, req_b, req_sub, resp_ready,
        output req_ready, resp_valid, resp_sum, resp_id
    );
    modport master (
        output req_valid, req_a, req_b, req_sub, resp_ready,
        input  req_ready, resp_valid, resp_sum, resp_id
    );
`else
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_sum, resp_id
    );
    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_sum, resp_id
    );
`endif
endinterface

// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter sharing one IEEE-754 single adder across NREQ requesters, two-stage pipe.
// Define FPADD_ARB_SUB_EN to add a per-requester subtract lane (A - B).
module fpadd_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input logic            clk,
    input logic            reset,
    fpadd_arbiter_if.slave bus
);

    // Round-to-nearest-even add with subnormals; NaNs are quieted and propagated (A first).
    function automatic logic [31:0] fpadd(input logic [31:0] a, input logic [31:0] b);
        logic        a_nan, b_nan, a_inf, b_inf, swap, sl, eff_sub, sticky, found, rnd;
        logic [7:0]  el, es, d;
        logic [26:0] ml, ms, sh_ms, m;
        logic [27:0] sum;
        logic [30:0] mag;
        logic [31:0] res;
        int          e, lz, sh;
        a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        swap    = b[30:0] > a[30:0];
        sl      = swap ? b[31] : a[31];
        eff_sub = a[31] ^ b[31];
        el      = swap ? b[30:23] : a[30:23];
        es      = swap ? a[30:23] : b[30:23];
        ml      = {el != 8'd0, swap ? b[22:0] : a[22:0], 3'b000};
        ms      = {es != 8'd0, swap ? a[22:0] : b[22:0], 3'b000};
        if (el == 8'd0) el = 8'd1;
        if (es == 8'd0) es = 8'd1;
        d      = el - es;
        sticky = 1'b0;
        sh_ms  = '0;
        if (d >= 8'd27) begin
            sticky = |ms;
        end else begin
            sh_ms  = ms >> d;
            sticky = |(ms & ((27'd1 << d) - 27'd1));
        end
        sh_ms[0] = sh_ms[0] | sticky;
        sum = eff_sub ? ({1'b0, ml} - {1'b0, sh_ms}) : ({1'b0, ml} + {1'b0, sh_ms});
        e     = int'(el);
        m     = sum[26:0];
        lz    = 0;
        sh    = 0;
        found = 1'b0;
        rnd   = 1'b0;
        mag   = '0;
        res   = '0;
        if (a_nan) begin
            res = a | 32'h0040_0000;
        end else if (b_nan) begin
            res = b | 32'h0040_0000;
        end else if (a_inf && b_inf) begin
            res = eff_sub ? 32'hFFC0_0000 : a;
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end else if (sum == 28'd0) begin
            res = {sl & ~eff_sub, 31'd0};
        end else begin
            if (sum[27]) begin
                m = {sum[27:2], sum[1] | sum[0]};
                e = e + 1;
            end else begin
                for (int i = 26; i >= 0; i--) begin
                    if (!found) begin
                        if (m[i]) found = 1'b1;
                        else      lz = lz + 1;
                    end
                end
                // Never normalise below the minimum exponent: that leaves a subnormal.
                sh = (lz < e - 1) ? lz : e - 1;
                m  = m << sh;
                e  = e - sh;
            end
            if (e >= 255) begin
                res = {sl, 8'hFF, 23'd0};
            end else begin
                // Rounding carry ripples from fraction into exponent (subnormal->normal, max->inf).
                mag = {(m[26] ? e[7:0] : 8'd0), m[25:3]};
                rnd = m[2] & (m[3] | m[1] | m[0]);
                res = {sl, mag + {30'd0, rnd}};
            end
        end
        return res;
    endfunction

    logic            s1_valid_q, s2_valid_q;
    logic [31:0]     s1_a_q, s1_b_q, s2_sum_q, s1_b_eff;
    logic [ID_W-1:0] s1_id_q, s2_id_q, ptr_q;
`ifdef FPADD_ARB_SUB_EN
    logic            s1_sub_q, sel_sub;
`endif

    logic            s2_free, s1_adv, s1_free, grant_any, take;
    logic [ID_W-1:0] win, cand, ptr_next;
    logic [NREQ-1:0] ready;
    logic [31:0]     sel_a, sel_b;

    assign s2_free = !s2_valid_q || bus.resp_ready;
    assign s1_adv  = s1_valid_q && s2_free;
    assign s1_free = !s1_valid_q || s2_free;
    assign take    = s1_free && grant_any && !reset;

    always_comb begin
        grant_any = 1'b0;
        win       = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % NREQ);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                win       = cand;
            end
        end
    end

    always_comb begin
        ready = '0;
        if (take) ready[win] = 1'b1;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
`ifdef FPADD_ARB_SUB_EN
        sel_sub = 1'b0;
`endif
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (ID_W'(k) == win) begin
                sel_a = bus.req_a[32*k +: 32];
                sel_b = bus.req_b[32*k +: 32];
`ifdef FPADD_ARB_SUB_EN
                sel_sub = bus.req_sub[k];
`endif
            end
        end
    end

    assign ptr_next = (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;

`ifdef FPADD_ARB_SUB_EN
    assign s1_b_eff = s1_b_q ^ {s1_sub_q, 31'd0};
`else
    assign s1_b_eff = s1_b_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_id_q    <= '0;
            ptr_q      <= '0;
`ifdef FPADD_ARB_SUB_EN
            s1_sub_q   <= 1'b0;
`endif
        end else begin
            if (take) begin
                s1_valid_q <= 1'b1;
                s1_a_q     <= sel_a;
                s1_b_q     <= sel_b;
                s1_id_q    <= win;
                ptr_q      <= ptr_next;
`ifdef FPADD_ARB_SUB_EN
                s1_sub_q   <= sel_sub;
`endif
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end
            if (s1_adv) begin
                s2_valid_q <= 1'b1;
                s2_sum_q   <= fpadd(s1_a_q, s1_b_eff);
                s2_id_q    <= s1_id_q;
            end else if (bus.resp_ready && s2_valid_q) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = s2_valid_q;
    assign bus.resp_sum   = s2_sum_q;
    assign bus.resp_id    = s2_id_q;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Bench for fpadd_arbiter: directed steps plus random traffic against a queue-based model
// whose sums come from real arithmetic rounded back to single precision.
module tb_fpadd_arbiter;
    localparam int unsigned NREQ = 4;

    typedef struct {
        logic [31:0] sum;
        int          id;
        int          due;
    } item_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpadd_arbiter_if #(.NREQ(NREQ)) bus ();
    fpadd_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .reset(reset), .bus(bus));

    item_t           fifo[$];
    int              ptr, edges, checks, errors;
    logic [NREQ-1:0] valid_r, sub_r, rdy_seen;
    logic [31:0]     a_r[NREQ];
    logic [31:0]     b_r[NREQ];

    function automatic real p2(input int k);
        return $bitstoreal({1'b0, 11'(k + 1023), 52'd0});
    endfunction

    function automatic real f2r(input logic [31:0] x);
        real v;
        if (x[30:23] == 8'd0) v = real'(x[22:0]) * p2(-149);
        else v = (real'(x[22:0]) + 8388608.0) * p2(int'(x[30:23]) - 150);
        return x[31] ? -v : v;
    endfunction

    // Round a double to the nearest single (ties to even), including subnormals and overflow.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] bits;
        real         x, q, n, fl;
        int          e;
        longint      base, k;
        bits = $realtobits(r);
        if (r == 0.0) return {bits[63], 31'd0};
        x = (r < 0.0) ? -r : r;
        e = int'(bits[62:52]) - 1023;
        if (e >= -126) begin
            q    = p2(e - 23);
            base = longint'(e + 126) <<< 23;
        end else begin
            q    = p2(-149);
            base = 0;
        end
        n  = x / q;
        fl = $floor(n);
        k  = longint'(fl);
        if ((n - fl) > 0.5 || ((n - fl) == 0.5 && k[0])) k++;
        k = base + k;
        if (k >= (longint'(255) <<< 23)) return {bits[63], 8'hFF, 23'd0};
        return {bits[63], k[30:0]};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b0,
                                            input logic sub);
        logic [31:0] b;
        b = sub ? (b0 ^ 32'h8000_0000) : b0;
        if (a[30:23] == 8'hFF && a[22:0] != 0) return a | 32'h0040_0000;
        if (b[30:23] == 8'hFF && b[22:0] != 0) return b | 32'h0040_0000;
        if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) return (a[31] == b[31]) ? a : 32'hFFC0_0000;
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        e = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(110, 140));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic new_op(input int i);
        a_r[i] = rand_op();
        b_r[i] = ($urandom_range(0, 5) == 0) ? (a_r[i] ^ 32'h8000_0000 ^ 32'($urandom_range(0, 7)))
                                             : rand_op();
`ifdef FPADD_ARB_SUB_EN
        sub_r[i] = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid = valid_r;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[32*i +: 32] = a_r[i];
            bus.req_b[32*i +: 32] = b_r[i];
        end
`ifdef FPADD_ARB_SUB_EN
        bus.req_sub = sub_r;
`endif
    endtask

    // One clock: check against the model at the falling edge, then advance past the rising edge.
    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        logic            exp_v, s;
        int              win, idx;
        @(negedge clk);
        exp_rdy = '0;
        win     = -1;
        if (!reset && (fifo.size() < 2 || bus.resp_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (ptr + k) % NREQ;
                if (win < 0 && valid_r[idx]) win = idx;
            end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
        rdy_seen = bus.req_ready;
        chk("req_ready", 32'(rdy_seen), 32'(exp_rdy));
        exp_v = (fifo.size() > 0) && (edges >= fifo[0].due);
        chk("resp_valid", 32'(bus.resp_valid), 32'(exp_v));
        if (exp_v) begin
            chk("resp_sum", bus.resp_sum, fifo[0].sum);
            chk("resp_id", 32'(bus.resp_id), 32'(fifo[0].id));
            if (bus.resp_ready) void'(fifo.pop_front());
        end
        if (win >= 0) begin
`ifdef FPADD_ARB_SUB_EN
            s = sub_r[win];
`else
            s = 1'b0;
`endif
            fifo.push_back('{sum: ref_add(a_r[win], b_r[win], s), id: win, due: edges + 2});
            ptr = (win + 1) % NREQ;
        end
        @(posedge clk);
        edges++;
        if (reset) begin
            fifo.delete();
            ptr = 0;
        end
        #1;
    endtask

    task automatic issue_one(input int id, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic [31:0] exp);
        valid_r     = '0;
        valid_r[id] = 1'b1;
        a_r[id]     = a;
        b_r[id]     = b;
        sub_r[id]   = s;
        drive();
        step();
        chk("one_grant", 32'(rdy_seen), 32'(1) << id);
        valid_r = '0;
        drive();
        step();
        chk("one_valid", 32'(bus.resp_valid), 32'd1);
        chk("one_sum", bus.resp_sum, exp);
        chk("one_id", 32'(bus.resp_id), 32'(id));
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ptr    = 0;
        edges  = 0;
        sub_r  = '0;
        for (int i = 0; i < NREQ; i++) new_op(i);
        sub_r          = '0;
        bus.resp_ready = 1'b1;

        // Reset with every requester valid: no grant may leak out.
        reset   = 1'b1;
        valid_r = '1;
        drive();
        step();
        step();
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_sum", bus.resp_sum, 32'd0);
        chk("rst_id", 32'(bus.resp_id), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        valid_r = '0;
        reset   = 1'b0;
        drive();
        step();

        issue_one(0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000);

        // All four hammering from reset: strict rotation, one result per cycle.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_r[i] = 32'h3FC0_0000;
            b_r[i] = 32'h4020_0000;
        end
        valid_r = '1;
        drive();
        for (int c = 0; c < 8; c++) begin
            step();
            chk("rr_order", 32'(rdy_seen), 32'(1) << (c % 4));
            if (c >= 1) begin
                chk("rr_valid", 32'(bus.resp_valid), 32'd1);
                chk("rr_sum", bus.resp_sum, 32'h4080_0000);
                chk("rr_id", 32'(bus.resp_id), 32'((c - 1) % 4));
            end
        end
        valid_r = '0;
        drive();
        repeat (3) step();

        // Backpressure with three pending requesters.
        bus.resp_ready = 1'b0;
        for (int i = 1; i < NREQ; i++) new_op(i);
        valid_r = 4'b1110;
        drive();
        repeat (5) begin
            step();
            valid_r &= ~rdy_seen;
            drive();
        end
        chk("bp_ready_zero", 32'(bus.req_ready), 32'd0);
        chk("bp_held_valid", 32'(bus.resp_valid), 32'd1);
        bus.resp_ready = 1'b1;
        repeat (6) begin
            step();
            valid_r &= ~rdy_seen;
            drive();
        end
        chk("bp_drained", 32'(bus.resp_valid), 32'd0);

        issue_one(1, 32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'hFFC0_0000);
        issue_one(1, 32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0001);
        issue_one(3, 32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000);
        issue_one(2, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000);

        // Reset one cycle after a grant: the in-flight pair vanishes and the pointer returns to 0.
        new_op(1);
        sub_r   = '0;
        valid_r = 4'b0010;
        drive();
        step();
        new_op(0);
        new_op(3);
        sub_r   = '0;
        valid_r = 4'b1001;
        reset   = 1'b1;
        drive();
        step();
        chk("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        drive();
        step();
        chk("mid_rst_prio", 32'(rdy_seen), 32'd1);
        valid_r &= ~rdy_seen;
        drive();
        repeat (4) begin
            step();
            valid_r &= ~rdy_seen;
            drive();
        end

`ifdef FPADD_ARB_SUB_EN
        issue_one(2, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000);
        issue_one(2, 32'h4040_0000, 32'h3F80_0000, 1'b0, 32'h4080_0000);
`endif

        // Random traffic with random consumer stalls.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!valid_r[i] && $urandom_range(0, 1) == 1) begin
                    new_op(i);
                    valid_r[i] = 1'b1;
                end
            end
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            drive();
            step();
            valid_r &= ~rdy_seen;
        end
        bus.resp_ready = 1'b1;
        repeat (12) begin
            drive();
            step();
            valid_r &= ~rdy_seen;
        end
        valid_r = '0;
        drive();
        repeat (3) step();
        chk("final_idle", 32'(bus.resp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fpadd_arbiter.md
Name: fpadd_arbiter

Overview:
- Shares one combinational fpadd instance (IEEE-754 single, 1+8+23) among NREQ requesters.
- Round-robin arbitration.
- Two-stage registered pipeline: operand register, then result register.
- Valid/ready handshake on both sides; full throughput of one add per cycle when the consumer never stalls.
- Sits between the scalar requesters (e.g. accumulator engines) and the shared adder.

Parameters:
NREQ, 4, number of requesters; legal range 2..16.
ID_W, $clog2(NREQ), width of the requester index carried with each result.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  NREQ  bit i: requester i presents an operand pair.
req_a  input  NREQ*32  operand A of requester i at bits [32*i+31:32*i].
req_b  input  NREQ*32  operand B of requester i, same packing.
req_ready  output  NREQ  one-hot (or zero) grant; handshake completes on valid&ready.
resp_valid  output  1  result register holds a valid sum.
resp_sum  output  32  A+B as produced by fpadd.
resp_id  output  ID_W  index of the requester that issued the pair.
resp_ready  input  1  consumer accepts result on resp_valid&resp_ready.

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - s1_valid=0, s2_valid=0, rr pointer=0.
  - resp_sum=0, resp_id=0.
  - Any in-flight operation is discarded without a response.
  - While reset=1, req_ready=0.
- Stage 1 register (s1): a, b, id, valid.
- Stage 2 register (s2): sum, id, valid.
  - resp_* outputs are driven directly from s2.
- Flow control:
  - s2_free = !s2_valid | resp_ready
  - s1_adv = s1_valid & s2_free
  - s1_free = !s1_valid | s2_free
- Grant:
  - Computed only when s1_free.
  - Searches req_valid starting at index ptr, then ptr+1 … wrapping modulo NREQ; the first set bit wins.
  - req_ready = onehot(winner) when s1_free, else 0.
  - req_ready may depend combinationally on req_valid and resp_ready.
  - req_valid must not depend on req_ready.
- On a granted handshake:
  - s1 <= {req_a[win], req_b[win], win, 1}.
  - ptr <= (win+1) mod NREQ.
  - ptr does not change in cycles with no grant.
- If s1_adv and no grant: s1_valid <= 0.
- If s1 stalled (!s2_free): s1 holds all fields.
- Stage 2 update:
  - If s1_adv: s2 <= {fpadd(s1_a, s1_b), s1_id, 1}.
  - Else if resp_ready & s2_valid: s2_valid <= 0; sum and id keep their last value.
  - Else s2 holds.
- Latency: handshake at edge k gives resp_valid=1 after edge k+1 (two registers, one edge apart). Result stays stable until accepted.
- Requesters hold valid and operands stable until ready. The arbiter never drops an accepted pair.
- Results return in grant order; there is no reordering.
- Special values are passed through fpadd unchanged:
  - NaN propagates.
  - inf + (−inf) = 32'hFFC00000.
  - Exact cancellation gives +0.
- Simultaneous events:
  - resp_ready with a new s1 advance in the same cycle: s2 is replaced with no bubble.
  - A grant with s1 advancing in the same cycle: s1 is replaced.
- A single requester that holds valid continuously gets one grant per cycle only when no other requester is valid. Otherwise grants rotate fairly; the worst-case wait is NREQ−1 grants.

Optional Feature:
Macro FPADD_ARB_SUB_EN.
- Defined:
  - Adds input port req_sub [NREQ-1:0].
  - s1 captures sub=req_sub[win]; operand B is fed to fpadd with bit 31 inverted when sub=1, giving A−B.
  - NaN B also has its sign flipped; the result is whatever fpadd returns.
- Undefined:
  - No req_sub port; always A+B.

Test Plan:
- Single request, resp_ready=1: req0 A=3F800000 (1.0), B=40000000 (2.0) -> one edge with req_ready[0]=1; resp_valid two edges later with resp_sum=40400000, resp_id=0.
- All four requesters valid continuously, resp_ready=1, from reset -> grant order 0,1,2,3,0,1; one resp per cycle; resp_id sequence matches; 3FC00000+40200000 gives 40800000.
- Backpressure: resp_ready=0 for 5 cycles with 3 pending requests -> s2 and s1 fill; req_ready=0 after two accepts; resp_sum/resp_id stable; on release, results drain in order without loss or duplication.
- Special values: 7F800000+FF800000 -> FFC00000; 7FC00001+3F800000 -> 7FC00001; 3F800000+BF800000 -> 00000000.
- Reset mid-operation: assert reset one cycle after a grant -> next cycle resp_valid=0, req_ready=0; after release, ptr=0 so requester 0 wins over 3 when both valid.
- With FPADD_ARB_SUB_EN: req2 A=40400000, B=3F800000, sub=1 -> resp_sum=40000000, resp_id=2; same pair with sub=0 -> 40800000.
